// File: rtl/avr_cpu_exec_mul_if.sv
// ---------------------------------------------------------------------------
// avr_cpu_exec_mul_if
// Request/response bundle between the execute stage and the multi-cycle
// multiply unit.
//
// Signals (direction seen from the multiply unit, i.e. the slave modport):
//   start        in   1    request, taken only when the unit is not busy
//   mode         in   3    0 MUL, 1 MULS, 2 MULSU, 3 FMUL, 4 FMULS, 5 FMULSU
//                          (6-7 behave as MUL)
//   d_in         in   W    multiplicand (Rd)
//   r_in         in   W    multiplier (Rr)
//   flush        in   1    synchronous abort of an operation in flight
//   busy         out  1    iteration in progress
//   hold         out  1    stall request to the core
//   done         out  1    one-cycle pulse, result and flags valid
//   result       out  2W   product (shifted left by one for FMUL modes)
//   flag_c       out  1    SREG C value
//   flag_z       out  1    SREG Z value
//   status_write out  1    same as done, core writes C and Z
// ---------------------------------------------------------------------------
interface avr_cpu_exec_mul_if #(
  parameter int W = 8
);
  logic           start;
  logic [2:0]     mode;
  logic [W-1:0]   d_in;
  logic [W-1:0]   r_in;
  logic           flush;
  logic           busy;
  logic           hold;
  logic           done;
  logic [2*W-1:0] result;
  logic           flag_c;
  logic           flag_z;
  logic           status_write;

  // Core side.
  modport master (
    output start, mode, d_in, r_in, flush,
    input  busy, hold, done, result, flag_c, flag_z, status_write
  );

  // Multiply unit side.
  modport slave (
    input  start, mode, d_in, r_in, flush,
    output busy, hold, done, result, flag_c, flag_z, status_write
  );
endinterface

// File: rtl/avr_cpu_exec_mul.sv
// ---------------------------------------------------------------------------
// avr_cpu_exec_mul
// Iterative multiply unit for the execute stage, covering the AVR
// MUL/MULS/MULSU/FMUL/FMULS/FMULSU family at operand width W. Operands are
// converted to magnitudes at accept, STEP multiplier bits are retired per
// cycle (N = W/STEP cycles), and the sign is re-applied on the last
// iteration. The core is stalled through hold while the unit computes.
//
// Ports:
//   clk  in  1   core clock, rising edge
//   rst  in  1   asynchronous, active-low reset
//   bus  slave modport of avr_cpu_exec_mul_if (start/mode/d_in/r_in/flush
//        in; busy/hold/done/result/flag_c/flag_z/status_write out)
//
// Parameters:
//   W     operand width, product is 2W bits
//   STEP  multiplier bits retired per cycle, W must be a multiple of STEP
// ---------------------------------------------------------------------------
module avr_cpu_exec_mul #(
  parameter int W    = 8,
  parameter int STEP = 2
) (
  input  logic               clk,
  input  logic               rst,
  avr_cpu_exec_mul_if.slave  bus
);

  localparam int N  = W / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * W;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t          r_state;
  logic            r_frac;
  logic            r_sign;
  logic [PW-1:0]   r_mcand;   // |Rd|, pre-shifted to the weight of the current step
  logic [W-1:0]    r_mplier;  // |Rr|, next STEP bits sit at the bottom
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [PW-1:0]   r_result;
  logic            r_flag_c;
  logic            r_flag_z;

  // -------------------------------------------------------------------------
  // Mode decode and operand magnitudes at accept
  // -------------------------------------------------------------------------
  logic          w_d_signed;
  logic          w_r_signed;
  logic          w_frac_in;
  logic          w_d_neg;
  logic          w_r_neg;
  logic [W-1:0]  w_d_abs;
  logic [W-1:0]  w_r_abs;

  always_comb begin
    w_d_signed = 1'b0;
    w_r_signed = 1'b0;
    w_frac_in  = 1'b0;
    case (bus.mode)
      3'd1: begin w_d_signed = 1'b1; w_r_signed = 1'b1; end
      3'd2: begin w_d_signed = 1'b1; end
      3'd3: begin w_frac_in  = 1'b1; end
      3'd4: begin w_d_signed = 1'b1; w_r_signed = 1'b1; w_frac_in = 1'b1; end
      3'd5: begin w_d_signed = 1'b1; w_frac_in  = 1'b1; end
      default: ;
    endcase
  end

  assign w_d_neg = w_d_signed & bus.d_in[W-1];
  assign w_r_neg = w_r_signed & bus.r_in[W-1];

  // The most negative value maps to 2^(W-1), which still fits in W unsigned bits.
  assign w_d_abs = w_d_neg ? (~bus.d_in + 1'b1) : bus.d_in;
  assign w_r_abs = w_r_neg ? (~bus.r_in + 1'b1) : bus.r_in;

  // -------------------------------------------------------------------------
  // One iteration: |Rd| times the next STEP bits of |Rr|
  // -------------------------------------------------------------------------
  logic [PW-1:0] w_pp [STEP];
  logic [PW-1:0] w_step_sum;
  logic [PW-1:0] w_acc_next;

  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_pp
      assign w_pp[gi] = r_mplier[gi] ? (r_mcand << gi) : '0;
    end
  endgenerate

  always_comb begin
    w_step_sum = '0;
    for (int j = 0; j < STEP; j++) begin
      w_step_sum = w_step_sum + w_pp[j];
    end
  end

  assign w_acc_next = r_acc + w_step_sum;

  // -------------------------------------------------------------------------
  // Final product, sign re-applied, fractional shift
  // -------------------------------------------------------------------------
  logic          w_last;
  logic [PW-1:0] w_prod;
  logic [PW-1:0] w_res_final;

  assign w_last      = (r_cnt == CW'(N - 1));
  assign w_prod      = r_sign ? (PW'(0) - w_acc_next) : w_acc_next;
  assign w_res_final = r_frac ? {w_prod[PW-2:0], 1'b0} : w_prod;

  // -------------------------------------------------------------------------
  // Control FSM with registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_frac   <= 1'b0;
      r_sign   <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // flush on the same edge drops the request
          if (bus.start && !bus.flush) begin
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
            r_frac   <= w_frac_in;
            r_sign   <= w_d_neg ^ w_r_neg;
            r_mcand  <= PW'(w_d_abs);
            r_mplier <= w_r_abs;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end

        S_RUN: begin
          if (bus.flush) begin
            // Abort quietly, result and flags keep the last completion.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << STEP;
            r_mplier <= r_mplier >> STEP;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
              r_state  <= S_IDLE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_result <= w_res_final;
              r_flag_c <= w_prod[PW-1];          // C is taken before the FMUL shift
              r_flag_z <= (w_res_final == '0);
            end
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // hold covers the request cycle itself so the core stalls before busy rises;
  // it drops in the done cycle to let the core advance and write back.
  assign bus.hold         = (bus.start && (r_state == S_IDLE)) || r_busy;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.status_write = r_done;
  assign bus.result       = r_result;
  assign bus.flag_c       = r_flag_c;
  assign bus.flag_z       = r_flag_z;

endmodule

// File: tb/tb_avr_cpu_exec_mul.sv
module tb_avr_cpu_exec_mul;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  avr_cpu_exec_mul_if #(.W(8))  bus8 ();
  avr_cpu_exec_mul_if #(.W(16)) bus16 ();

  avr_cpu_exec_mul #(.W(8), .STEP(2)) u_dut8 (
    .clk (clk),
    .rst (rst_n),
    .bus (bus8)
  );

  avr_cpu_exec_mul #(.W(16), .STEP(4)) u_dut16 (
    .clk (clk),
    .rst (rst_n),
    .bus (bus16)
  );

  // ---------------------------------------------------------------------
  // Reference arithmetic: plain signed integer multiply
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [63:0] res;
    logic        c;
    logic        z;
  } ref_t;

  function automatic ref_t ref_mul(input int w, input logic [2:0] md,
                                   input logic [31:0] d, input logic [31:0] r);
    ref_t        o;
    longint      dv, rv;
    logic [63:0] p, mask;
    bit          ds, rs, fr;
    ds   = (md == 3'd1) || (md == 3'd2) || (md == 3'd4) || (md == 3'd5);
    rs   = (md == 3'd1) || (md == 3'd4);
    fr   = (md >= 3'd3) && (md <= 3'd5);
    dv   = longint'({32'd0, d});
    rv   = longint'({32'd0, r});
    if (ds && d[w-1]) dv = dv - (longint'(1) << w);
    if (rs && r[w-1]) rv = rv - (longint'(1) << w);
    mask = (64'd1 << (2 * w)) - 64'd1;
    p    = 64'(dv * rv) & mask;
    o.c  = p[2*w-1];
    o.res = fr ? ((p << 1) & mask) : p;
    o.z  = (o.res == 64'd0);
    return o;
  endfunction

  // ---------------------------------------------------------------------
  // Check bookkeeping: every comparison is performed by the compare process
  // ---------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } req_t;
  req_t req_q[$];

  task automatic expect_eq(input string nm, input logic [63:0] act, input logic [63:0] exp);
    req_t rq;
    rq.name = nm;
    rq.act  = act;
    rq.exp  = exp;
    req_q.push_back(rq);
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Cycle model of the W=8 unit: counts down the N iteration cycles
  // ---------------------------------------------------------------------
  localparam int N8 = 4;
  int          m_left;
  ref_t        m_pend;
  logic [15:0] m_res;
  logic        m_c, m_z, m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_res  <= '0;
      m_c    <= 1'b0;
      m_z    <= 1'b0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (bus8.flush) begin
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_res  <= m_pend.res[15:0];
            m_c    <= m_pend.c;
            m_z    <= m_pend.z;
            m_done <= 1'b1;
          end
        end
      end else if (bus8.start && !bus8.flush) begin
        m_pend <= ref_mul(8, bus8.mode, {24'd0, bus8.d_in}, {24'd0, bus8.r_in});
        m_left <= N8;
      end
    end
  end

  // Compare process: queued directed checks plus per-cycle model checks.
  always @(negedge clk) begin
    while (req_q.size() > 0) begin
      req_t rq;
      rq = req_q.pop_front();
      check(rq.name, rq.act, rq.exp);
    end
    if (rst_n === 1'b1) begin
      check("cyc_busy",   64'(bus8.busy),         64'(m_left > 0));
      check("cyc_done",   64'(bus8.done),         64'(m_done));
      check("cyc_sw",     64'(bus8.status_write), 64'(m_done));
      check("cyc_hold",   64'(bus8.hold),         64'((bus8.start && m_left == 0) || (m_left > 0)));
      check("cyc_result", 64'(bus8.result),       64'(m_res));
      check("cyc_c",      64'(bus8.flag_c),       64'(m_c));
      check("cyc_z",      64'(bus8.flag_z),       64'(m_z));
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after the rising edge)
  // ---------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic op8(input logic [2:0] md, input logic [7:0] d, input logic [7:0] r,
                     input logic [15:0] er, input logic ec, input logic ez, input string nm);
    int lat;
    int hc;
    bus8.mode  = md;
    bus8.d_in  = d;
    bus8.r_in  = r;
    bus8.start = 1'b1;
    #1;
    hc = int'(bus8.hold);
    tick();
    // Scramble operands after accept; they must not matter any more.
    bus8.start = 1'b0;
    bus8.d_in  = ~d;
    bus8.r_in  = r ^ 8'h5A;
    bus8.mode  = md ^ 3'd3;
    lat = 0;
    while (!bus8.done && lat < 20) begin
      hc += int'(bus8.hold);
      tick();
      lat++;
    end
    expect_eq({nm, "_lat"},  64'(lat),         64'd4);
    expect_eq({nm, "_hold"}, 64'(hc),          64'd5);
    expect_eq({nm, "_res"},  64'(bus8.result), 64'(er));
    expect_eq({nm, "_c"},    64'(bus8.flag_c), 64'(ec));
    expect_eq({nm, "_z"},    64'(bus8.flag_z), 64'(ez));
    $display("op8 %s mode=%0d d=%h r=%h result=%h c=%b z=%b lat=%0d",
             nm, md, d, r, bus8.result, bus8.flag_c, bus8.flag_z, lat);
  endtask

  task automatic op16(input logic [2:0] md, input logic [15:0] d, input logic [15:0] r,
                      input logic [31:0] er, input logic ec, input logic ez, input string nm);
    int lat;
    bus16.mode  = md;
    bus16.d_in  = d;
    bus16.r_in  = r;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    bus16.d_in  = ~d;
    lat = 0;
    while (!bus16.done && lat < 20) begin
      tick();
      lat++;
    end
    expect_eq({nm, "_lat"}, 64'(lat),          64'd4);
    expect_eq({nm, "_res"}, 64'(bus16.result), 64'(er));
    expect_eq({nm, "_c"},   64'(bus16.flag_c), 64'(ec));
    expect_eq({nm, "_z"},   64'(bus16.flag_z), 64'(ez));
    $display("op16 %s mode=%0d d=%h r=%h result=%h c=%b z=%b lat=%0d",
             nm, md, d, r, bus16.result, bus16.flag_c, bus16.flag_z, lat);
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin
    int   lat;
    int   dcnt;
    ref_t e;
    logic [2:0] md;
    logic [7:0] d, r;
    logic [15:0] d16, r16;

    rst_n       = 1'b0;
    bus8.start  = 1'b0;  bus8.mode  = '0; bus8.d_in  = '0; bus8.r_in  = '0; bus8.flush  = 1'b0;
    bus16.start = 1'b0;  bus16.mode = '0; bus16.d_in = '0; bus16.r_in = '0; bus16.flush = 1'b0;

    repeat (2) tick();
    expect_eq("rst_busy",   64'(bus8.busy),    64'd0);
    expect_eq("rst_done",   64'(bus8.done),    64'd0);
    expect_eq("rst_hold",   64'(bus8.hold),    64'd0);
    expect_eq("rst_result", 64'(bus8.result),  64'd0);
    expect_eq("rst_c",      64'(bus8.flag_c),  64'd0);
    expect_eq("rst_z",      64'(bus8.flag_z),  64'd0);
    expect_eq("rst_res16",  64'(bus16.result), 64'd0);
    rst_n = 1'b1;

    // Pin the reference model to hand-computed products.
    expect_eq("model_mul_ff",    ref_mul(8, 3'd0, 32'hFF, 32'hFF).res, 64'hFE01);
    expect_eq("model_muls_fe",   ref_mul(8, 3'd1, 32'hFE, 32'h03).res, 64'hFFFA);
    expect_eq("model_fmulsu",    ref_mul(8, 3'd5, 32'hC0, 32'h80).res, 64'hC000);
    expect_eq("model_fmulsu_c",  64'(ref_mul(8, 3'd5, 32'hC0, 32'h80).c), 64'd1);
    expect_eq("model_muls16",    ref_mul(16, 3'd1, 32'h8000, 32'h7FFF).res, 64'hC000_8000);

    tick();
    op8(3'd0, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0, "mul_ff_ff");      tick();
    op8(3'd1, 8'h80, 8'h80, 16'h4000, 1'b0, 1'b0, "muls_80_80");     tick();
    op8(3'd2, 8'hFF, 8'h02, 16'hFFFE, 1'b1, 1'b0, "mulsu_ff_02");    tick();
    op8(3'd1, 8'hFE, 8'h03, 16'hFFFA, 1'b1, 1'b0, "muls_fe_03");     tick();
    op8(3'd3, 8'h80, 8'h80, 16'h8000, 1'b0, 1'b0, "fmul_80_80");     tick();
    op8(3'd4, 8'h80, 8'h80, 16'h8000, 1'b0, 1'b0, "fmuls_80_80");    tick();
    op8(3'd5, 8'hC0, 8'h80, 16'hC000, 1'b1, 1'b0, "fmulsu_c0_80");   tick();
    op8(3'd0, 8'h00, 8'h37, 16'h0000, 1'b0, 1'b1, "mul_zero");       tick();
    op8(3'd6, 8'h10, 8'h10, 16'h0100, 1'b0, 1'b0, "mode6_as_mul");   tick();
    op8(3'd7, 8'hFF, 8'h02, 16'h01FE, 1'b0, 1'b0, "mode7_as_mul");   tick();

    // Back-to-back: second start issued in the done cycle of the first.
    op8(3'd0, 8'h12, 8'h34, 16'h03A8, 1'b0, 1'b0, "b2b_first");
    op8(3'd1, 8'hF0, 8'h10, 16'hFF00, 1'b1, 1'b0, "b2b_second");
    tick();

    // start pulsed again mid-RUN must be ignored.
    bus8.mode = 3'd0; bus8.d_in = 8'h05; bus8.r_in = 8'h07; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0; lat = 0;
    tick(); lat++;
    bus8.start = 1'b1; bus8.d_in = 8'hFF; bus8.r_in = 8'hFF;
    tick(); lat++;
    bus8.start = 1'b0;
    while (!bus8.done && lat < 20) begin
      tick();
      lat++;
    end
    expect_eq("ign_lat", 64'(lat),         64'd4);
    expect_eq("ign_res", 64'(bus8.result), 64'h0023);
    dcnt = 0;
    repeat (6) begin
      tick();
      if (bus8.done) dcnt++;
    end
    expect_eq("ign_no_second_done", 64'(dcnt), 64'd0);
    $display("op8 ignore_midrun result=%h extra_done=%0d", bus8.result, dcnt);

    // flush at iteration 2: no done, previous result retained.
    bus8.mode = 3'd0; bus8.d_in = 8'h12; bus8.r_in = 8'h34; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    bus8.flush = 1'b1;
    tick();
    bus8.flush = 1'b0;
    dcnt = 0;
    repeat (6) begin
      if (bus8.done) dcnt++;
      tick();
    end
    expect_eq("flush_no_done", 64'(dcnt),         64'd0);
    expect_eq("flush_busy",    64'(bus8.busy),    64'd0);
    expect_eq("flush_keep_res", 64'(bus8.result), 64'h0023);
    $display("op8 flush_run result=%h done_seen=%0d", bus8.result, dcnt);

    // flush together with start in IDLE: request dropped.
    bus8.d_in = 8'h33; bus8.r_in = 8'h33; bus8.start = 1'b1; bus8.flush = 1'b1;
    tick();
    bus8.start = 1'b0; bus8.flush = 1'b0;
    expect_eq("flush_start_busy", 64'(bus8.busy), 64'd0);
    dcnt = 0;
    repeat (6) begin
      if (bus8.done) dcnt++;
      tick();
    end
    expect_eq("flush_start_no_done", 64'(dcnt), 64'd0);
    $display("op8 flush_with_start busy=%b done_seen=%0d", bus8.busy, dcnt);

    // Reset mid-RUN: outputs clear immediately.
    bus8.mode = 3'd0; bus8.d_in = 8'hFF; bus8.r_in = 8'hFF; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    expect_eq("midrst_busy",   64'(bus8.busy),   64'd0);
    expect_eq("midrst_hold",   64'(bus8.hold),   64'd0);
    expect_eq("midrst_done",   64'(bus8.done),   64'd0);
    expect_eq("midrst_result", 64'(bus8.result), 64'd0);
    expect_eq("midrst_c",      64'(bus8.flag_c), 64'd0);
    $display("op8 reset_midrun busy=%b result=%h", bus8.busy, bus8.result);
    tick();
    rst_n = 1'b1;
    tick();

    // Random sweep over all modes, alternating idle gaps and back-to-back.
    for (int i = 0; i < 40; i++) begin
      md = 3'($urandom_range(0, 7));
      d  = 8'($urandom);
      r  = 8'($urandom);
      e  = ref_mul(8, md, {24'd0, d}, {24'd0, r});
      op8(md, d, r, e.res[15:0], e.c, e.z, "sweep");
      if (i % 2 == 0) tick();
    end
    tick();

    // W=16, STEP=4 instance.
    op16(3'd1, 16'h8000, 16'h7FFF, 32'hC000_8000, 1'b1, 1'b0, "muls16");
    tick();
    for (int i = 0; i < 8; i++) begin
      md  = 3'($urandom_range(0, 7));
      d16 = 16'($urandom);
      r16 = 16'($urandom);
      e   = ref_mul(16, md, {16'd0, d16}, {16'd0, r16});
      op16(md, d16, r16, e.res[31:0], e.c, e.z, "sweep16");
      tick();
    end

    // Let the compare process drain the queue before the summary.
    repeat (3) @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/avr_cpu_exec_mul.md
Name: avr_cpu_exec_mul

Overview:
Parametrised multi-cycle multiply unit for the CPU execute stage. It covers the AVR MUL/MULS/MULSU/FMUL/FMULS/FMULSU family at configurable operand width, and computes iteratively at a configurable number of product bits per cycle. It stalls the core through `hold` while computing, then presents a 2W-bit product plus C/Z flags for writeback to R1:R0 and SREG.

Parameters:
- W, 8, operand width in bits; the product is 2W bits.
- STEP, 2, multiplier bits retired per cycle; W % STEP must be 0; N = W/STEP iteration cycles.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only when `busy`=0.
- mode  in  3  0 MUL, 1 MULS, 2 MULSU, 3 FMUL, 4 FMULS, 5 FMULSU; 6-7 behave as MUL.
- d_in  in  W  multiplicand (Rd).
- r_in  in  W  multiplier (Rr).
- flush  in  1  synchronous abort of an operation in flight.
- busy  out  1  iteration in progress.
- hold  out  1  stall request to the core.
- done  out  1  one-cycle pulse: result and flags valid.
- result  out  2W  product (shifted left 1 for FMUL modes).
- flag_c  out  1  SREG C value.
- flag_z  out  1  SREG Z value.
- status_write  out  1  equals `done`; core writes C and Z.

Behaviour:
- Reset (rst=0, async): FSM to IDLE; `busy`, `done`, `result`, `flag_c` and `flag_z` all 0.
- FSM states:
  - IDLE -> RUN on `start`=1.
  - RUN stays for N cycles, then goes to IDLE with `done`=1.
- Accept (IDLE, `start`=1):
  - Latch `mode`, |Rd| and |Rr| per signedness, and sign = sign(Rd) XOR sign(Rr).
  - MULS/FMULS: both operands signed. MULSU/FMULSU: Rd signed, Rr unsigned. Others: unsigned.
  - Clear the accumulator and iteration counter; `busy`=1.
- RUN: each cycle add (|Rd| x next STEP bits of |Rr|), shifted, into the accumulator; increment the counter.
- Final iteration edge:
  - P = sign ? -acc : acc (2W-bit two's complement).
  - `flag_c` = P[2W-1].
  - `result` = FMUL modes ? P<<1 (bit 0 = 0) : P.
  - `flag_z` = (`result` == 0).
  - `done`=1 for exactly the next cycle; `busy`=0 in that same cycle.
- Latency: `start` sampled at edge k -> `done` high during cycle k+N (N=4 at defaults).
- Output hold: `result`, `flag_c` and `flag_z` stay unchanged until the next completion or reset. They are not cleared on accept.
- `hold` = (`start` AND IDLE) OR `busy` (combinational). It is low in the `done` cycle so the core advances and performs writeback.
- `start` while `busy`: ignored, no queuing.
- `start` in the `done` cycle: accepted; back-to-back operations are legal.
- `flush` in RUN: go to IDLE next edge; no `done`; outputs retain their prior values. `flush` in IDLE: no effect. `flush` and `start` together in IDLE: `flush` wins, request dropped.
- Reset mid-operation: immediate abort; all outputs 0.
- Operands are sampled only at accept. Later changes on `d_in`/`r_in`/`mode` have no effect.

Test Plan:
- Basic MUL: W=8, STEP=2; MUL 0xFF x 0xFF -> `done` exactly 4 cycles after `start` edge; `result`=0xFE01, C=1, Z=0; `hold` high 5 cycles, including the `start` cycle.
- Signed modes:
  - MULS 0x80 x 0x80 -> 0x4000, C=0.
  - MULSU 0xFF x 0x02 -> 0xFFFE, C=1.
  - MULS 0xFE x 0x03 -> 0xFFFA, C=1.
- Fractional modes:
  - FMUL 0x80 x 0x80 -> 0x8000, C=0.
  - FMULS 0x80 x 0x80 -> 0x8000, C=0.
  - FMULSU 0xC0 x 0x80 -> 0xC000, C=1.
- Zero result: MUL 0x00 x 0x37 -> 0x0000, Z=1, C=0.
- Handshake rules:
  - Pulse `start` again mid-RUN -> ignored.
  - `start` during the `done` cycle -> second result 4 cycles later.
  - `flush` at iteration 2 -> no `done`; previous `result` retained.
- Reset and sweep:
  - Drop `rst` mid-RUN -> outputs 0 immediately.
  - Re-run with W=16, STEP=4: MULS 0x8000 x 0x7FFF -> 0xC0008000, `done` after 4 cycles.
  - Random sweep for all modes against a reference model.
